// File: rtl/seq_braun_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with
// valid/ready handshakes on both sides.
// Optional feature macro: MULT_SIGNED_EN (per-transaction two's-complement mode
// selected by sgn). When undefined, sgn is ignored and all operands are unsigned.
module seq_braun_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               sgn,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW    = 2 * WIDTH;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    prod_q, prod_d;

   logic             load;
   logic             neg_q;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [PW-1:0]    pp, sum;

`ifdef MULT_SIGNED_EN
   // Loop always runs on magnitudes; -2^(WIDTH-1) maps onto 2^(WIDTH-1) unsigned.
   assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
   assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

   // Result sign is captured with the operands and applied once the loop ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q <= 1'b0;
      end else if (load) begin
         neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      end
   end
`else
   logic unused_sgn;
   assign unused_sgn = sgn;
   assign a_mag      = a;
   assign b_mag      = b;
   assign neg_q      = 1'b0;
`endif

   assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
   assign out_valid = (state_q == StDone);
   assign prod      = prod_q;
   assign load      = in_valid & in_ready;

   // Partial product for the current multiplier bit, zero-extended and shifted into place.
   assign pp  = b_q[0] ? (PW'(a_q) << cnt_q) : '0;
   assign sum = acc_q + pp;

   // Next-state logic for the control FSM and the datapath registers.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      prod_d  = prod_q;

      case (state_q)
         StIdle: ;
         StBusy: begin
            acc_d = sum;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StDone;
               cnt_d   = '0;
               prod_d  = neg_q ? -sum : sum;
            end
         end
         StDone: begin
            if (out_ready && !in_valid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Also covers the back-to-back case from StDone, skipping the idle bubble.
      if (load) begin
         state_d = StBusy;
         a_d     = a_mag;
         b_d     = b_mag;
         acc_d   = '0;
         cnt_d   = '0;
      end
   end

   // State and datapath registers; reset discards any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
      end
   end

endmodule

// File: tb/tb_seq_braun_mult.sv
// Self-checking bench for seq_braun_mult (WIDTH=8): directed cases followed by
// randomized traffic with input/output stalls against an arithmetic reference.
module tb_seq_braun_mult;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        sgn;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] prod;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_braun_mult #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sgn       (sgn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference product from plain integer arithmetic.
   function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
      logic signed [15:0] sx, sy;
      logic unused_s;
      unused_s = s;
      sx = 16'(signed'(x));
      sy = 16'(signed'(y));
`ifdef MULT_SIGNED_EN
      if (s) return 16'(sx * sy);
`endif
      return 16'({8'h00, x} * {8'h00, y});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
      a        = x;
      b        = y;
      sgn      = s;
      in_valid = 1'b1;
      #1;
      check("in_ready_at_send", in_ready, 1);
      tick();
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
   endtask

   task automatic wait_result(input string tag, input logic [15:0] exp);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         check({tag, "_busy_in_ready"}, in_ready, 0);
         tick();
         n++;
      end
      check({tag, "_latency"}, n, 8);
      check({tag, "_prod"}, prod, exp);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_after_accept", out_valid, 0);
   endtask

   logic [15:0] q[$];
   logic [15:0] prod_prev;
   logic        stall_prev;
   logic        seen;
   int          sent, got, cyc;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sgn       = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_prod", prod, 0);
      rst = 1'b0;

      // Basic product and zero/all-ones boundaries.
      send(8'd13, 8'd11, 1'b0);
      wait_result("t13x11", 16'd143);
      accept();
      send(8'd255, 8'd255, 1'b0);
      wait_result("t255x255", 16'd65025);
      accept();
      // out_ready already high during BUSY must not shorten latency.
      out_ready = 1'b1;
      send(8'd0, 8'd200, 1'b0);
      wait_result("t0x200", 16'd0);
      tick();
      out_ready = 1'b0;
      check("early_ready_accepted", out_valid, 0);
      send(8'hFD, 8'd5, 1'b0);
      wait_result("tFDx5_unsigned", 16'd1265);
      accept();

      // Output stall, then back-to-back input at the releasing edge.
      send(8'd100, 8'd3, 1'b0);
      wait_result("t100x3", 16'd300);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_out_valid", out_valid, 1);
         check("hold_prod", prod, 300);
      end
      out_ready = 1'b1;
      send(8'd21, 8'd5, 1'b0);
      out_ready = 1'b0;
      wait_result("t21x5_b2b", 16'd105);
      accept();

      // Reset mid-BUSY with a concurrent in_valid: nothing stale, nothing accepted.
      send(8'd7, 8'd9, 1'b0);
      tick();
      tick();
      tick();
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 8'd5;
      b        = 8'd5;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_prod", prod, 0);
      check("midrst_in_ready", in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_stale", seen, 0);

`ifdef MULT_SIGNED_EN
      send(8'h80, 8'h80, 1'b1);
      wait_result("s_m128xm128", 16'd16384);
      accept();
      send(8'hFD, 8'd5, 1'b1);
      wait_result("s_m3x5", 16'hFFF1);
      accept();
      send(8'd127, 8'hFF, 1'b1);
      wait_result("s_127xm1", 16'hFF81);
      accept();
`endif

      // Randomized traffic with stalls on both sides.
      sent       = 0;
      got        = 0;
      cyc        = 0;
      stall_prev = 1'b0;
      prod_prev  = '0;
      while ((sent < 1000 || got < sent) && cyc < 40000) begin
         in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
         a         = 8'($urandom);
         b         = 8'($urandom);
         sgn       = 1'($urandom);
         out_ready = ($urandom_range(3) != 0);
         #1;
         if (stall_prev) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_prod", prod, prod_prev);
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, sgn));
            sent++;
         end
         if (out_valid && out_ready) begin
            check("rand_expected_pending", q.size() > 0, 1);
            if (q.size() > 0) check("rand_prod", prod, q.pop_front());
            got++;
         end
         stall_prev = out_valid && !out_ready;
         prod_prev  = prod;
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("rand_no_timeout", cyc < 40000, 1);
      check("rand_result_count", got, 1000);
      check("rand_leftover", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
